// File: rtl/cpu_ctrl_pkg.sv
// Shared LEGv8 decode types: opcode constants, ALU ops, immediate formats and ID/EX control bundle.
package cpu_ctrl_pkg;

  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_B  = 2'b01,
    IMM_CB = 2'b10,
    IMM_D  = 2'b11
  } imm_sel_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_EOR   = 3'd4,
    ALU_LSL   = 3'd5,
    ALU_LSR   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  // Opcodes are matched on instr[31:21], [31:22], [31:24] and [31:26] respectively.
  localparam logic [10:0] OP_ADDS  = 11'h558;
  localparam logic [10:0] OP_SUBS  = 11'h758;
  localparam logic [10:0] OP_AND   = 11'h450;
  localparam logic [10:0] OP_ORR   = 11'h550;
  localparam logic [10:0] OP_EOR   = 11'h650;
  localparam logic [10:0] OP_LSL   = 11'h69B;
  localparam logic [10:0] OP_LSR   = 11'h69A;
  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [9:0]  OP_ADDI  = 10'h244;
  localparam logic [9:0]  OP_SUBI  = 10'h344;
  localparam logic [7:0]  OP_CBZ   = 8'hB4;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  localparam logic [5:0]  OP_B     = 6'h05;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    set_flags;
    logic    uncond_br;
    logic    cond_br;
    alu_op_t alu_op;
    logic [4:0] rd;
  } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational LEGv8 opcode decode: controls, immediate format, source-register use and legality.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output imm_sel_t    imm_sel_o,
  output logic        use_rn_o,
  output logic        use_rm_o,
  output logic        use_rt_o,
  output logic        legal_o
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic        unused_bits;

  assign op11        = instr_i[31:21];
  assign op10        = instr_i[31:22];
  assign op8         = instr_i[31:24];
  assign op6         = instr_i[31:26];
  assign unused_bits = ^instr_i[20:5];

  always_comb begin
    ctrl_o    = '0;
    imm_sel_o = IMM_I;
    use_rn_o  = 1'b0;
    use_rm_o  = 1'b0;
    use_rt_o  = 1'b0;
    legal_o   = 1'b1;
    if (op11 == OP_ADDS || op11 == OP_SUBS || op11 == OP_AND || op11 == OP_ORR ||
        op11 == OP_EOR  || op11 == OP_LSL  || op11 == OP_LSR) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.set_flags = (op11 == OP_ADDS) || (op11 == OP_SUBS);
      use_rn_o = 1'b1;
      use_rm_o = 1'b1;
      case (op11)
        OP_SUBS: ctrl_o.alu_op = ALU_SUB;
        OP_AND:  ctrl_o.alu_op = ALU_AND;
        OP_ORR:  ctrl_o.alu_op = ALU_ORR;
        OP_EOR:  ctrl_o.alu_op = ALU_EOR;
        OP_LSL:  ctrl_o.alu_op = ALU_LSL;
        OP_LSR:  ctrl_o.alu_op = ALU_LSR;
        default: ctrl_o.alu_op = ALU_ADD;
      endcase
    end else if (op11 == OP_LDUR) begin
      ctrl_o.reg_write  = 1'b1;
      ctrl_o.mem_read   = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.alu_src    = 1'b1;
      imm_sel_o = IMM_D;
      use_rn_o  = 1'b1;
    end else if (op11 == OP_STUR) begin
      ctrl_o.mem_write = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      imm_sel_o = IMM_D;
      use_rn_o  = 1'b1;
      use_rt_o  = 1'b1;
    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.alu_op    = (op10 == OP_SUBI) ? ALU_SUB : ALU_ADD;
      use_rn_o = 1'b1;
    end else if (op8 == OP_CBZ) begin
      ctrl_o.cond_br = 1'b1;
      ctrl_o.alu_op  = ALU_PASSB;
      imm_sel_o = IMM_CB;
      use_rt_o  = 1'b1;
    end else if (op8 == OP_BCOND) begin
      // B.cond tests the flags only; its Rt field carries the condition code
      ctrl_o.cond_br = 1'b1;
      imm_sel_o = IMM_CB;
    end else if (op6 == OP_B) begin
      ctrl_o.uncond_br = 1'b1;
      imm_sel_o = IMM_B;
    end else begin
      legal_o = 1'b0;
    end
    if (ctrl_o.reg_write) ctrl_o.rd = instr_i[4:0];
  end

endmodule

// File: rtl/decode_control_unit.sv
// LEGv8 ID stage: IF/ID register, decode, one-bubble load-use stall FSM and ID/EX control register.
// Defining DECODE_ILLEGAL_TRAP_EN adds the illegal_op pulse and sticky illegal_seen outputs.
module decode_control_unit
  import cpu_ctrl_pkg::ctrl_t, cpu_ctrl_pkg::imm_sel_t;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = cpu_ctrl_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  input  logic             flush,
  output logic             stall_out,
  output logic [31:0]      id_instr,
  output logic [1:0]       imm_sel,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_alu_src,
  output logic             ex_set_flags,
  output logic             ex_uncond_br,
  output logic             ex_cond_br,
  output logic [2:0]       ex_alu_op,
  output logic [REG_W-1:0] ex_rd
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_op,
  output logic             illegal_seen
`endif
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] id_instr_q;
  logic        id_valid_q;
  ctrl_t       ex_ctrl_q, ex_ctrl_d;
  logic        ex_valid_q, ex_valid_d;

  ctrl_t      dec_ctrl;
  imm_sel_t   dec_imm;
  logic       use_rn, use_rm, use_rt, legal;
  logic [REG_W-1:0] rn, rm, rt, ex_rd_w;
  logic       hazard, stall;

  opcode_decoder u_dec (
    .instr_i  (id_instr_q),
    .ctrl_o   (dec_ctrl),
    .imm_sel_o(dec_imm),
    .use_rn_o (use_rn),
    .use_rm_o (use_rm),
    .use_rt_o (use_rt),
    .legal_o  (legal)
  );

  assign rn      = REG_W'(id_instr_q[9:5]);
  assign rm      = REG_W'(id_instr_q[20:16]);
  assign rt      = REG_W'(id_instr_q[4:0]);
  assign ex_rd_w = REG_W'(ex_ctrl_q.rd);

  // XZR reads never depend on an in-flight load
  assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_w != REG_W'(ZERO_REG)) && id_valid_q &&
                  ((use_rn && rn == ex_rd_w) || (use_rm && rm == ex_rd_w) || (use_rt && rt == ex_rd_w));
  assign stall  = (state_q == RUN) && hazard && !flush;

  always_comb begin
    ex_ctrl_d  = '0;
    ex_valid_d = 1'b0;
    if (!(flush || hazard || !id_valid_q || !legal)) begin
      ex_ctrl_d  = dec_ctrl;
      ex_valid_d = 1'b1;
    end
    state_d = (state_q == RUN && stall) ? BUBBLE : RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_valid_q <= ex_valid_d;
      if (flush) begin
        id_valid_q <= 1'b0;
      end else if (!stall) begin
        id_instr_q <= if_instr;
        id_valid_q <= if_valid;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_seen_q, illegal_d;

  assign illegal_d = id_valid_q && !legal && !flush && !hazard;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_q      <= illegal_d;
      illegal_seen_q <= illegal_seen_q | illegal_d;
    end
  end

  assign illegal_op   = illegal_q;
  assign illegal_seen = illegal_seen_q;
`endif

  assign stall_out     = stall;
  assign id_instr      = id_instr_q;
  assign imm_sel       = dec_imm;
  assign ex_valid      = ex_valid_q;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_set_flags  = ex_ctrl_q.set_flags;
  assign ex_uncond_br  = ex_ctrl_q.uncond_br;
  assign ex_cond_br    = ex_ctrl_q.cond_br;
  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_rd         = ex_rd_w;

endmodule

// File: doc/decode_control_unit.md
Name: decode_control_unit

Overview:
- ID-stage controller for the 5-stage LEGv8 pipeline.
- Latches the fetched instruction into the IF/ID register and drives imm_sel to the immediate sign extender (I=00, B=01, CB=10, D=11).
- Decodes the opcode into ID/EX control signals, detects load-use hazards and inserts bubbles.
- Honours flush requests from branch resolution.

Parameters:
- REG_W, 5, register-address width.
- ZERO_REG, 31, index of XZR; never a hazard source.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_instr  in  32  instruction from fetch.
- if_valid  in  1  if_instr is valid this cycle.
- flush  in  1  squash the ID and EX control contents (taken branch).
- stall_out  out  1  hold PC and IF; high during a load-use bubble.
- id_instr  out  32  registered IF/ID instruction, feeds the register file and sign extender.
- imm_sel  out  2  sign-extender format select, combinational from id_instr.
- ex_valid  out  1  ID/EX slot holds a real instruction.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_set_flags, ex_uncond_br, ex_cond_br  out  1 each  registered ID/EX controls.
- ex_alu_op  out  3  registered ALU operation.
- ex_rd  out  REG_W  registered destination register.

Behaviour:
- Reset: every registered output, id_instr and all internal state go to 0 immediately when reset_n falls.
- Reset wins over all other inputs. A reset mid-bubble returns the FSM to RUN.
- IF/ID register update:
  - If flush: id_valid <= 0 (id_instr value is don't-care).
  - Else if stall_out: hold.
  - Else: id_instr <= if_instr, id_valid <= if_valid.
- Decode (combinational), opcode to format / imm_sel:
  - ADDI, SUBI -> I, 00.
  - B -> B, 01.
  - CBZ, B.cond -> CB, 10.
  - LDUR, STUR -> D, 11.
  - R-type (ADDS, SUBS, AND, ORR, EOR, LSL, LSR) -> 00 (don't-care).
  - Undefined opcode -> NOP.
- Source registers:
  - Rn = instr[9:5]; Rm = instr[20:16] for R-type.
  - Rt = instr[4:0] for STUR and CBZ.
  - A source equal to ZERO_REG is ignored.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd != ZERO_REG && id_valid && (ex_rd equals any used source).
- FSM, 2 states:
  - RUN: on hazard && !flush, assert stall_out (combinational), load a bubble into ID/EX, go to BUBBLE.
  - BUBBLE: stall_out=0; the held instruction advances; return to RUN.
  - Exactly one bubble per load-use pair.
- ID/EX update, every cycle: flush, hazard or !id_valid loads all-zero controls and ex_valid=0. Otherwise the decoded controls are loaded with ex_valid=1.
- Latency: instruction on if_instr at edge N appears as EX controls after edge N+2 (no hazard).
- Simultaneous events:
  - flush beats hazard: stall_out=0 and the FSM stays in RUN.
  - A hazard on the cycle after a bubble cannot recur, because the load has left EX.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output illegal_op (1).
  - illegal_op pulses one cycle, registered alongside ID/EX, when a valid, unflushed undefined opcode leaves ID.
  - Adds sticky output illegal_seen, cleared only by reset.
- When undefined: undefined opcodes silently become bubbles, and neither port exists.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - imm_sel_t enum (IMM_I, IMM_B, IMM_CB, IMM_D).
  - Opcode constants for every supported instruction.
  - alu_op_t.
  - ctrl_t packed struct of the ID/EX controls.
  - Constant ZERO_REG.
- One sub-module: opcode_decoder (combinational; instruction -> ctrl_t, imm_sel, source-use flags, legal flag).
- Pipeline registers, hazard detection and FSM stay in decode_control_unit.

Test Plan:
- Reset then ADDI X1,X2,#5 with if_valid=1: imm_sel=00 one cycle later. Two edges after issue: ex_reg_write=1, ex_alu_src=1, ex_rd=1, ex_valid=1. All outputs were 0 during reset.
- LDUR X3,[X4,#8] followed by ADDS X5,X3,X6:
  - stall_out=1 for exactly one cycle; ex_valid=0 bubble.
  - ADDS reaches EX one cycle late; id_instr held.
- LDUR X31,[X4,#0] then ADDS X5,X31,X6: no stall (ZERO_REG).
- STUR X7,[X1,#0] after LDUR X7: stall via Rt. CBZ X7 after LDUR X7: stall; imm_sel=10.
- flush asserted in the same cycle as a load-use hazard: stall_out=0, ex_valid=0 next cycle, id_valid=0, FSM in RUN.
- Opcode 0x0000_0000 with DECODE_ILLEGAL_TRAP_EN: illegal_op pulses once, illegal_seen stays 1 until reset_n=0. Without the macro: ex_valid=0.
